// File: rtl/serial_receiver_8bit.sv
// serial_receiver_8bit: serial-in/parallel-out receiver with a held output
// register, a valid/ack handshake and a sticky overrun flag. Bits keep
// arriving while a finished word waits for ack, so reception is double-buffered.
module serial_receiver_8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             sh,
    input  logic             clear,
    input  logic             ack,
    output logic [WIDTH-1:0] parallel_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_count
);

    // IDLE means no partial word is held; SHIFT means some bits have arrived.
    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] pout_next;
    logic             valid_next;
    logic             overrun_next;
    logic             complete;

    // The receive state is fully implied by the bit counter, so it is decoded
    // from it rather than stored separately.
    always_comb begin
        state = IDLE;
        if (bit_count != '0) begin
            state = SHIFT;
        end
    end

    assign busy = (state == SHIFT);

    // Candidate word for this edge, and whether this edge finishes a word.
    assign word     = {serial_in, shreg[WIDTH-1:1]};
    assign complete = sh && (bit_count == CNT_W'(WIDTH - 1));

    // Next-state logic. Clear wins over sampling but still lets ack retire the
    // pending word. A completion that meets an unacknowledged word is dropped
    // and flagged; one that meets an ack replaces the word in the same edge.
    always_comb begin
        shreg_next   = shreg;
        count_next   = bit_count;
        pout_next    = parallel_out;
        valid_next   = valid;
        overrun_next = overrun;
        if (clear) begin
            shreg_next   = '0;
            count_next   = '0;
            overrun_next = 1'b0;
            if (valid && ack) begin
                valid_next = 1'b0;
            end
        end else begin
            if (sh) begin
                shreg_next = word;
                if (complete) begin
                    count_next = '0;
                    if (!valid || ack) begin
                        pout_next  = word;
                        valid_next = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end else begin
                    count_next = bit_count + CNT_W'(1);
                end
            end
            if (!complete && valid && ack) begin
                valid_next = 1'b0;
            end
        end
    end

    // State register with synchronous reset; reset drops both the partial
    // word and any word waiting to be acknowledged.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg        <= '0;
            bit_count    <= '0;
            parallel_out <= '0;
            valid        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            shreg        <= shreg_next;
            bit_count    <= count_next;
            parallel_out <= pout_next;
            valid        <= valid_next;
            overrun      <= overrun_next;
        end
    end

endmodule
